train_track_model: RTL and testbench
====================================

Name: train_track_model

Overview:
- Behavioural-synthesizable model of the two-train track plant, the other end of the controller interface.
- Consumes the controller's switch word and drive codes, moves two trains around their loops and the single shared segment, and produces the sensor word back to the controller.
- Used in closed-loop benches and FPGA demos. Flags protocol violations: driving into a misaligned switch, switching under an occupied segment, and collisions.

Parameters:
- LOOP_CYCLES, 16: enabled cycles a train spends on its own loop between shared-segment exit and entry sensor.
- SHARED_CYCLES, 8: enabled cycles to traverse the shared segment.
- A_START, 4: initial loop count for train A after reset.
- B_START, 10: initial loop count for train B after reset.
- CNT_W, 8: counter width; must hold max(LOOP_CYCLES, SHARED_CYCLES, A_START, B_START).

Ports:
- Clock  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- SW  in  3 [3:1]  switch word; 3'b000 = shared segment aligned to A, 3'b011 = aligned to B, anything else = aligned to neither.
- DA  in  2 [1:0]  train A drive; 2'b01 = go, any other code = stop.
- DB  in  2 [1:0]  train B drive; same encoding as DA.
- SR  out  4 [4:1]  sensors: [1] A at entry (level), [2] B at entry (level), [3] A exit (1-cycle pulse), [4] B exit (1-cycle pulse).
- OCC  out  2 [1:0]  shared-segment occupancy; bit0 = A, bit1 = B.
- ERR  out  1  sticky protocol-violation flag.
- COLLIDE  out  1  sticky flag; set when both trains occupy the shared segment.

Behaviour:
- All outputs are registered.
- RESET low asynchronously forces: SR=0, OCC=0, ERR=0, COLLIDE=0; train A to RUN with cnt=A_START; train B to RUN with cnt=B_START.
- Per-train FSM with states RUN, ENTRY and SHARED. "Enabled" means the train's drive input equals 2'b01 in that cycle. Description below is for A; B is identical with DB, SW_B, SR[2], SR[4] and OCC[1].
- RUN, enabled: if cnt==1, go to ENTRY; otherwise cnt-1. Not enabled: hold.
- SR[1] is 1 for exactly the cycles A is in ENTRY. First ENTRY cycle follows the A_START-th enabled edge after reset.
- ENTRY, enabled and SW==3'b000: go to SHARED with cnt=SHARED_CYCLES; SR[1] falls and OCC[0] rises on the same edge.
- ENTRY, enabled and SW!=3'b000: stay in ENTRY and set ERR.
- ENTRY, not enabled: hold.
- SHARED, enabled: if cnt==1, go to RUN with cnt=LOOP_CYCLES, clear OCC[0], and assert SR[3] for exactly one cycle (the first RUN cycle); otherwise cnt-1. Not enabled: hold, and counting resumes on the next enabled cycle.
- Switch under load: SW changing value while OCC!=0 sets ERR on that edge. Comparison is against the previous registered SW.
- Collision: registered OCC==2'b11 sets COLLIDE on the following edge.
- ERR and COLLIDE clear only on reset.
- Simultaneous events: both trains may be in ENTRY at once. At most one can be aligned; the aligned one enters, and the other sets ERR only if enabled. Exit of one train and entry of the other on the same edge is legal and does not set COLLIDE.
- Counters never wrap: cnt is reloaded before reaching 0. Parameter values of 0 are illegal and checked by an elaboration assertion.

Decomposition:
- Package train_pkg holds:
  - drive codes: DRV_GO=2'b01, DRV_STOP=2'b00;
  - switch codes: SW_TO_A=3'b000, SW_TO_B=3'b011;
  - per-train state encoding: RUN, ENTRY, SHARED (one-hot, 3 bits).
- Sub-module train_segment, instantiated twice. Parameters: START, LOOP_CYCLES, SHARED_CYCLES, ALIGN_CODE. Inputs: drive code and switch word. Outputs: at_entry, exit_pulse, occupied, misaligned_go.
- Top level adds the SR packing, switch-change detection, and the ERR/COLLIDE sticky logic.

Test Plan:
- Release reset with DA=DB=01, SW=000 -> SR[1]=1 after edge 4; SR[1]=0 and OCC=01 after edge 5; SR[3] high for exactly one cycle after edge 13, with OCC=00 on the same edge; ERR=0.
- Hold DA=00 for 20 cycles, then 01 -> SR[1] rises on the 4th edge after DA goes to 01 (counter frozen while stopped).
- SW=000, DB=01: B reaches ENTRY (SR[2]=1 after edge 10) -> ERR=1 on edge 11, B held with SR[2]=1; then SW=011 -> B enters (OCC[1]=1) and ERR stays 1.
- A in SHARED (OCC=01), SW flips 000->011 -> ERR=1 that edge; B then enters -> OCC=11 and COLLIDE=1 one edge later; both flags stay set.
- DA=00 for 3 cycles mid-SHARED -> SR[3] pulse delayed by exactly 3 cycles relative to the first scenario.
- Assert RESET low between clock edges while A is SHARED -> SR, OCC, ERR, COLLIDE are 0 immediately without a clock edge; after release, first scenario timing repeats exactly.

Source files
------------

// File: rtl/train_pkg.sv
// Shared codes and state encoding for the two-train track plant model.
package train_pkg;

  localparam int unsigned DRV_W   = 2;
  localparam int unsigned SW_W    = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [DRV_W-1:0] DRV_GO   = 2'b01;
  localparam logic [DRV_W-1:0] DRV_STOP = 2'b00;

  localparam logic [SW_W-1:0] SW_TO_A = 3'b000;
  localparam logic [SW_W-1:0] SW_TO_B = 3'b011;

  // One-hot per-train position state.
  typedef enum logic [STATE_W-1:0] {
    RUN    = 3'b001,
    ENTRY  = 3'b010,
    SHARED = 3'b100
  } seg_state_e;

endpackage

// File: rtl/train_segment.sv
// One train: runs its private loop, waits at the entry sensor, crosses the shared segment.
module train_segment
  import train_pkg::*;
#(
  parameter int unsigned     START         = 4,
  parameter int unsigned     LOOP_CYCLES   = 16,
  parameter int unsigned     SHARED_CYCLES = 8,
  parameter int unsigned     CNT_W         = 8,
  parameter logic [SW_W-1:0] ALIGN_CODE    = SW_TO_A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DRV_W-1:0] drive,
  input  logic [SW_W-1:0]  sw,
  output logic             at_entry,
  output logic             exit_pulse,
  output logic             occupied,
  output logic             misaligned_go_c
);

  if (START == 0 || LOOP_CYCLES == 0 || SHARED_CYCLES == 0 || CNT_W == 0) begin : g_zero_param
    $error("train_segment: zero-valued parameter is illegal");
  end
  if (START >= (64'd1 << CNT_W) || LOOP_CYCLES >= (64'd1 << CNT_W) ||
      SHARED_CYCLES >= (64'd1 << CNT_W)) begin : g_cnt_too_narrow
    $error("train_segment: CNT_W too narrow for parameters");
  end

  seg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             go;
  logic             aligned;

  assign go      = (drive == DRV_GO);
  assign aligned = (sw == ALIGN_CODE);

  // Driving into the entry while the switch points elsewhere.
  assign misaligned_go_c = go && (state == ENTRY) && !aligned;

  // Position FSM with registered sensor and occupancy outputs; counter only moves when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= CNT_W'(START);
      at_entry   <= 1'b0;
      occupied   <= 1'b0;
      exit_pulse <= 1'b0;
    end else begin
      exit_pulse <= 1'b0;
      if (go) begin
        unique case (state)
          RUN: begin
            if (cnt == CNT_W'(1)) begin
              state    <= ENTRY;
              at_entry <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ENTRY: begin
            if (aligned) begin
              state    <= SHARED;
              cnt      <= CNT_W'(SHARED_CYCLES);
              at_entry <= 1'b0;
              occupied <= 1'b1;
            end
          end
          SHARED: begin
            if (cnt == CNT_W'(1)) begin
              state      <= RUN;
              cnt        <= CNT_W'(LOOP_CYCLES);
              occupied   <= 1'b0;
              exit_pulse <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state    <= RUN;
            cnt      <= CNT_W'(LOOP_CYCLES);
            at_entry <= 1'b0;
            occupied <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/train_track_model.sv
// Two-train track plant: two trains sharing one segment, sensor word and violation flags.
module train_track_model
  import train_pkg::*;
#(
  parameter int unsigned LOOP_CYCLES   = 16,
  parameter int unsigned SHARED_CYCLES = 8,
  parameter int unsigned A_START       = 4,
  parameter int unsigned B_START       = 10,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:1]       sw,
  input  logic [DRV_W-1:0] da,
  input  logic [DRV_W-1:0] db,
  output logic [4:1]       sr,
  output logic [1:0]       occ,
  output logic             err,
  output logic             collide
);

  logic            a_entry, a_exit, a_occ, a_mis;
  logic            b_entry, b_exit, b_occ, b_mis;
  logic [SW_W-1:0] sw_q;

  train_segment #(
    .START(A_START), .LOOP_CYCLES(LOOP_CYCLES), .SHARED_CYCLES(SHARED_CYCLES),
    .CNT_W(CNT_W), .ALIGN_CODE(SW_TO_A)
  ) u_train_a (
    .clk(clk), .rst_n(rst_n), .drive(da), .sw(sw),
    .at_entry(a_entry), .exit_pulse(a_exit), .occupied(a_occ), .misaligned_go_c(a_mis)
  );

  train_segment #(
    .START(B_START), .LOOP_CYCLES(LOOP_CYCLES), .SHARED_CYCLES(SHARED_CYCLES),
    .CNT_W(CNT_W), .ALIGN_CODE(SW_TO_B)
  ) u_train_b (
    .clk(clk), .rst_n(rst_n), .drive(db), .sw(sw),
    .at_entry(b_entry), .exit_pulse(b_exit), .occupied(b_occ), .misaligned_go_c(b_mis)
  );

  // Sensor and occupancy words are straight packings of per-train flops.
  assign sr  = {b_exit, a_exit, b_entry, a_entry};
  assign occ = {b_occ, a_occ};

  // Sticky violation flags; switch change is judged against last sampled switch word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q    <= SW_TO_A;
      err     <= 1'b0;
      collide <= 1'b0;
    end else begin
      sw_q <= sw;
      if (a_mis || b_mis || ((occ != 2'b00) && (sw != sw_q))) begin
        err <= 1'b1;
      end
      if (occ == 2'b11) begin
        collide <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_train_track_model.sv
// Directed bench for the two-train track plant model.
module tb_train_track_model;
  import train_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:1] sw = 3'b000;
  logic [1:0] da = 2'b00;
  logic [1:0] db = 2'b00;
  logic [4:1] sr;
  logic [1:0] occ;
  logic       err;
  logic       collide;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] da;
    logic [1:0] db;
    logic [2:0] sw;
    logic [3:0] e_sr;
    logic [1:0] e_occ;
    logic       e_err;
    logic       e_col;
  } vec_t;

  vec_t tbl [16];

  train_track_model dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .da(da), .db(db),
    .sr(sr), .occ(occ), .err(err), .collide(collide)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_sr, input logic [1:0] e_occ,
                           input logic e_err, input logic e_col);
    chk({tag, ".sr"},      8'(sr),      8'(e_sr));
    chk({tag, ".occ"},     8'(occ),     8'(e_occ));
    chk({tag, ".err"},     8'(err),     8'(e_err));
    chk({tag, ".collide"}, 8'(collide), 8'(e_col));
  endtask

  task automatic do_reset(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
    rst_n = 1'b0;
    da = a;
    db = b;
    sw = s;
    step();
    step();
    check_all("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      da = tbl[i].da;
      db = tbl[i].db;
      sw = tbl[i].sw;
      step();
      check_all($sformatf("%s_e%0d", tag, i + 1), tbl[i].e_sr, tbl[i].e_occ,
                tbl[i].e_err, tbl[i].e_col);
    end
  endtask

  initial begin
    int first;
    int highs;

    // Both trains go, switch to A; B stalls misaligned at entry until switch goes to B.
    tbl[0]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 2'b01, 3'b000, 4'b0001, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b01, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b01, 1'b0, 1'b0};
    tbl[7]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b01, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 2'b01, 3'b000, 4'b0000, 2'b01, 1'b0, 1'b0};
    tbl[9]  = '{2'b01, 2'b01, 3'b000, 4'b0010, 2'b01, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 2'b01, 3'b000, 4'b0010, 2'b01, 1'b1, 1'b0};
    tbl[11] = '{2'b01, 2'b01, 3'b000, 4'b0010, 2'b01, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 2'b01, 3'b000, 4'b0110, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{2'b01, 2'b01, 3'b000, 4'b0010, 2'b00, 1'b1, 1'b0};
    tbl[14] = '{2'b01, 2'b01, 3'b011, 4'b0000, 2'b10, 1'b1, 1'b0};
    tbl[15] = '{2'b01, 2'b01, 3'b011, 4'b0000, 2'b10, 1'b1, 1'b0};

    // Baseline run from reset.
    do_reset(DRV_GO, DRV_GO, SW_TO_A);
    run_table("base");

    // A stopped for 20 cycles: counter must be frozen.
    do_reset(DRV_STOP, DRV_STOP, SW_TO_A);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("stop_e%0d.sr", k + 1), 8'(sr), 8'h00);
    end
    da = DRV_GO;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (sr[1] && first == 0) first = k;
    end
    chk("stop_release.entry_edge", 8'(first), 8'd4);

    // Switch flips under A, B enters aligned to B: ERR then collision.
    do_reset(DRV_GO, DRV_GO, SW_TO_A);
    for (int k = 0; k < 7; k++) step();
    check_all("col_e7", 4'b0000, 2'b01, 1'b0, 1'b0);
    sw = SW_TO_B;
    step();
    check_all("col_e8", 4'b0000, 2'b01, 1'b1, 1'b0);
    step();
    step();
    check_all("col_e10", 4'b0010, 2'b01, 1'b1, 1'b0);
    step();
    check_all("col_e11", 4'b0000, 2'b11, 1'b1, 1'b0);
    step();
    check_all("col_e12", 4'b0000, 2'b11, 1'b1, 1'b1);
    step();
    check_all("col_e13", 4'b0100, 2'b10, 1'b1, 1'b1);

    // A paused 3 cycles mid-segment: exit pulse moves from edge 13 to edge 16.
    do_reset(DRV_GO, DRV_STOP, SW_TO_A);
    for (int k = 0; k < 7; k++) step();
    da = DRV_STOP;
    for (int k = 8; k <= 10; k++) begin
      step();
      check_all($sformatf("pause_e%0d", k), 4'b0000, 2'b01, 1'b0, 1'b0);
    end
    da = DRV_GO;
    first = 0;
    highs = 0;
    for (int k = 11; k <= 18; k++) begin
      step();
      if (sr[3]) begin
        highs++;
        if (first == 0) first = k;
      end
      if (k == 15) chk("pause_e15.occ", 8'(occ), 8'h01);
      if (k == 16) chk("pause_e16.occ", 8'(occ), 8'h00);
    end
    chk("pause.exit_edge", 8'(first), 8'd16);
    chk("pause.exit_width", 8'(highs), 8'd1);

    // Asynchronous reset between edges while A occupies the segment.
    do_reset(DRV_GO, DRV_GO, SW_TO_A);
    for (int k = 0; k < 7; k++) step();
    chk("areset_pre.occ", 8'(occ), 8'h01);
    sw = SW_TO_B;
    step();
    chk("areset_pre.err", 8'(err), 8'h01);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("areset_now", 4'b0000, 2'b00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    run_table("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
